// File: rtl/lsu_pkg.sv
// lsu_pkg: shared FSM states, funct3 encodings and byte-strobe constants for the load/store unit
package lsu_pkg;
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [3:0] STRB_B = 4'b0001;
    localparam logic [3:0] STRB_H = 4'b0011;
    localparam logic [3:0] STRB_W = 4'b1111;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: request legality check, store lane steering/strobes and load byte extraction with extension
module lsu_align
    import lsu_pkg::*;
(
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [1:0]  req_off,
    input  logic [31:0] req_wdata,
    output logic        req_err,
    output logic [3:0]  st_strb,
    output logic [31:0] st_wdata,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);
    logic        illegal;
    logic        misal;
    logic [31:0] sh;

    always_comb begin
        illegal  = req_we ? (req_funct3 > F3_W) : (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11);
        misal    = (req_funct3[1:0] == 2'b01 && req_off[0]) || (req_funct3[1:0] == 2'b10 && req_off != 2'b00);
        req_err  = illegal | misal;
        st_strb  = !req_we ? 4'b0000 :
                   req_funct3[1:0] == 2'b00 ? STRB_B << req_off :
                   req_funct3[1:0] == 2'b01 ? STRB_H << req_off : STRB_W;
        st_wdata = req_funct3[1:0] == 2'b00 ? {4{req_wdata[7:0]}} :
                   req_funct3[1:0] == 2'b01 ? {2{req_wdata[15:0]}} : req_wdata;
        sh       = ld_word >> {ld_off, 3'b000};
        ld_data  = ld_funct3 == F3_B  ? {{24{sh[7]}}, sh[7:0]} :
                   ld_funct3 == F3_H  ? {{16{sh[15]}}, sh[15:0]} :
                   ld_funct3 == F3_BU ? {24'b0, sh[7:0]} :
                   ld_funct3 == F3_HU ? {16'b0, sh[15:0]} : sh;
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle load/store FSM between execute stage and a handshaked data-memory bus
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned XLEN           = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_addr,
    output logic            mem_we,
    output logic [3:0]      mem_wstrb,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_rsp_err
);
    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [31:0] cnt_q, cnt_d;
    logic        a_err;
    logic [3:0]  a_strb;
    logic [31:0] a_wdata;
    logic [31:0] ld_data;

    lsu_align u_align (
        .req_we    (req_we),
        .req_funct3(req_funct3),
        .req_off   (req_addr[1:0]),
        .req_wdata (req_wdata),
        .req_err   (a_err),
        .st_strb   (a_strb),
        .st_wdata  (a_wdata),
        .ld_funct3 (funct3_q),
        .ld_off    (addr_q[1:0]),
        .ld_word   (mem_rdata),
        .ld_data   (ld_data)
    );

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: if (req_valid) begin
                we_d     = req_we;
                funct3_d = req_funct3;
                addr_d   = req_addr;
                wdata_d  = a_wdata;
                wstrb_d  = a_strb;
                rdata_d  = 32'b0;
                err_d    = a_err;
                state_d  = a_err ? RESP : REQ;
            end
            REQ: if (mem_req_ready) begin
                state_d = WAIT;
                cnt_d   = 32'b0;
            end
            WAIT: if (mem_rsp_valid) begin
                state_d = RESP;
                err_d   = mem_rsp_err;
                rdata_d = (we_q | mem_rsp_err) ? 32'b0 : ld_data;
            end else if (TIMEOUT_CYCLES != 0 && cnt_q == TIMEOUT_CYCLES - 1) begin
                state_d = RESP;
                err_d   = 1'b1;
                rdata_d = 32'b0;
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'b0;
            addr_q   <= 32'b0;
            wdata_q  <= 32'b0;
            wstrb_q  <= 4'b0;
            rdata_q  <= 32'b0;
            err_q    <= 1'b0;
            cnt_q    <= 32'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign req_ready     = state_q == IDLE;
    assign mem_req_valid = state_q == REQ;
    assign mem_addr      = {addr_q[31:2], 2'b00};
    assign mem_we        = mem_req_valid & we_q;
    assign mem_wstrb     = mem_req_valid ? wstrb_q : 4'b0;
    assign mem_wdata     = wdata_q;
    assign resp_valid    = state_q == RESP;
    assign resp_rdata    = resp_valid ? rdata_q : 32'b0;
    assign resp_err      = resp_valid & err_q;
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Multi-cycle load/store unit between the execute stage (ALU result as address, rs2 as store data) and a handshaked data-memory bus. It is the downstream consumer of the ALU result. The writeback mux and the stall logic consume its response.
It replaces the inverted-clock single-cycle DMEM access. It provides byte lane steering, sign/zero extension, misalignment detection and bus timeout.

Parameters:
TIMEOUT_CYCLES, 255, cycles spent in WAIT before a forced error response; 0 disables the timeout.
XLEN, 32, data/address width. Only 32 is supported.

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
req_valid  in  1  core issues load/store
req_ready  out  1  unit can accept a request (IDLE only)
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
req_addr  in  32  byte address (ALU result)
req_wdata  in  32  store data (rs2)
resp_valid  out  1  one-cycle pulse; request complete
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_err  out  1  misaligned, illegal funct3, bus error or timeout
mem_req_valid  out  1  bus request
mem_req_ready  in  1  bus accepts request
mem_addr  out  32  word-aligned address {addr[31:2],2'b00}
mem_we  out  1  bus write
mem_wstrb  out  4  byte enables; 0000 on loads
mem_wdata  out  32  lane-steered store data
mem_rsp_valid  in  1  bus response
mem_rdata  in  32  bus read word
mem_rsp_err  in  1  bus error with response

Behaviour:
- States: IDLE, REQ, WAIT, RESP. Reset (synchronous, rst=1 at edge) takes the unit to IDLE and clears all outputs to 0 except req_ready=1. Reset mid-transaction abandons it; no resp_valid is generated.
- IDLE: req_ready=1.
  - req_valid with a legal, aligned request: latch we, funct3, addr, steered wdata and strobes, then go to REQ.
  - Illegal or misaligned request: go directly to RESP with err=1, rdata=0. No bus activity.
- Illegal funct3: loads 011/110/111; stores anything other than 000/001/010.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0.
- REQ: mem_req_valid=1. mem_addr, mem_we, mem_wstrb and mem_wdata are held stable until mem_req_ready=1, then go to WAIT. The timeout counter clears on entering WAIT.
- WAIT: mem_req_valid=0, and the counter increments each cycle.
  - On mem_rsp_valid: capture formatted data and err=mem_rsp_err, then go to RESP.
  - Otherwise, if TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1: go to RESP with err=1, rdata=0.
  - If mem_rsp_valid and the timeout coincide, the response wins.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. resp_rdata/resp_err are valid only while resp_valid=1 and are zeroed otherwise.
- mem_rsp_valid in IDLE, REQ or RESP is ignored, including late responses after a timeout.
- Latency: request accepted at edge N (in REQ at N+1). If mem_req_ready=1 in cycle N+1 and mem_rsp_valid=1 in N+2, resp_valid=1 in cycle N+3. An error detected in IDLE gives resp_valid in cycle N+1.
- Stores:
  - SB: wstrb=0001<<addr[1:0], wdata={4{rs2[7:0]}}.
  - SH: wstrb=0011<<addr[1:0], wdata={2{rs2[15:0]}}.
  - SW: wstrb=1111, wdata=rs2.
  - Store resp_rdata=0.
- Loads: shift mem_rdata right by addr[1:0]*8. LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes through.
- One transaction outstanding at a time. req_ready=0 outside IDLE. Requests while busy are not accepted, and the core must hold them.

Decomposition:
- Shared package lsu_pkg: state enum (IDLE/REQ/WAIT/RESP), funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU, strobe constants.
- Sub-module lsu_align (combinational): store lane steering + strobe generation, load extraction/extension, misalign/illegal detection.
- Top FSM, latches and timeout counter live in load_store_unit.

Test Plan:
- SW addr=0x1000, wdata=0xDEADBEEF, bus ready immediately, rsp next cycle -> mem_addr=0x1000, wstrb=1111, mem_wdata=0xDEADBEEF; resp_valid in cycle N+3, err=0, rdata=0.
- SB addr=0x1003, wdata=0x000000A5 -> wstrb=1000, mem_wdata=0xA5A5A5A5, mem_addr=0x1000.
- LB addr=0x2002, mem_rdata=0x12F03456 -> resp_rdata=0xFFFFFFF0. LBU same address -> 0x000000F0. LHU addr=0x2002 -> 0x000012F0.
- LW addr=0x3001 -> resp_valid in N+1, err=1, mem_req_valid never asserted. Funct3=011 load -> same error behaviour.
- mem_req_ready held 0 for 5 cycles -> mem_req_valid and payload stable throughout, req_ready=0. Then ready=1 with mem_rsp_err=1 -> resp_err=1.
- TIMEOUT_CYCLES=4, no rsp -> resp_valid, err=1 after 4 WAIT cycles. A late mem_rsp_valid in IDLE is ignored. rst asserted while in WAIT -> IDLE next edge with no resp_valid.
